// File: rtl/fibonacci_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fibonacci_gen
//  Description : Iterative Fibonacci term generator. Computes F(n) mod 2^W,
//                flags overflow of the true F(n), optionally streams every
//                term F(0)..F(n), and can be aborted mid-run.
//  Revision    : 1.0  initial release
// ============================================================================
module fibonacci_gen #(
    parameter int W  = 16,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          abort,
    input  logic          stream,
    input  logic [NW-1:0] n,
    output logic          busy,
    output logic          done_tick,
    output logic [W-1:0]  result,
    output logic          ovf,
    output logic          term_valid,
    output logic [W-1:0]  term,
    output logic [NW-1:0] term_idx
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;          // F(k)
    logic [W-1:0]    r_b;          // F(k+1)
    logic [NW-1:0]   r_k;
    logic [NW-1:0]   r_n_q;
    logic            r_stream_q;
    logic            r_ovf_acc;

    logic [W:0]      w_sum;
    logic [NW:0]     w_k_plus2;
    logic            w_next_in_range;

    // Next term with its carry; k+2 is widened so the range test never wraps.
    assign w_sum           = {1'b0, r_a} + {1'b0, r_b};
    assign w_k_plus2       = {1'b0, r_k} + (NW+1)'(2);
    assign w_next_in_range = (w_k_plus2 <= {1'b0, r_n_q});

    // Sequencer and datapath: all outputs registered, pulses cleared each edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_n_q      <= '0;
            r_stream_q <= 1'b0;
            r_ovf_acc  <= 1'b0;
            busy       <= 1'b0;
            done_tick  <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
            term_valid <= 1'b0;
            term       <= '0;
            term_idx   <= '0;
        end else begin
            done_tick  <= 1'b0;
            term_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Abort takes priority over a simultaneous start.
                    if (!abort && start) begin
                        r_n_q      <= n;
                        r_stream_q <= stream;
                        r_a        <= '0;
                        r_b        <= W'(1);
                        r_k        <= '0;
                        r_ovf_acc  <= 1'b0;
                        busy       <= 1'b1;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (abort) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        term       <= r_a;
                        term_idx   <= r_k;
                        term_valid <= r_stream_q;
                        if (r_k == r_n_q) begin
                            result    <= r_a;
                            ovf       <= r_ovf_acc;
                            done_tick <= 1'b1;
                            busy      <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_a <= r_b;
                            r_b <= w_sum[W-1:0];
                            r_k <= r_k + NW'(1);
                            // Only a carry into a term that will actually be
                            // reached (index <= n) counts as overflow.
                            if (w_sum[W] && w_next_in_range) begin
                                r_ovf_acc <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_fibonacci_gen
//  Description : Self-checking bench for fibonacci_gen. A cycle-level model
//                derived from the Fibonacci definition is compared against
//                every DUT output each cycle; directed runs pin literal values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fibonacci_gen;

    localparam int W  = 16;
    localparam int NW = 5;
    localparam longint MASK = (64'd1 << W) - 1;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic          abort;
    logic          stream;
    logic [NW-1:0] n;
    logic          busy;
    logic          done_tick;
    logic [W-1:0]  result;
    logic          ovf;
    logic          term_valid;
    logic [W-1:0]  term;
    logic [NW-1:0] term_idx;

    int vectors;
    int miscompares;

    fibonacci_gen #(.W(W), .NW(NW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .stream     (stream),
        .n          (n),
        .busy       (busy),
        .done_tick  (done_tick),
        .result     (result),
        .ovf        (ovf),
        .term_valid (term_valid),
        .term       (term),
        .term_idx   (term_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact Fibonacci number (fits easily in 64 bits for n < 32).
    function automatic longint fib(input int idx);
        longint x, y, t;
        x = 0;
        y = 1;
        for (int i = 0; i < idx; i++) begin
            t = x + y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic          m_busy, m_done, m_tv, m_ovf;
    logic [W-1:0]  m_result, m_term;
    logic [NW-1:0] m_idx;
    bit            m_active;
    int            m_n;
    bit            m_stream;
    int            m_step;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 0; m_done = 0; m_tv = 0; m_ovf = 0;
            m_result = '0; m_term = '0; m_idx = '0;
            m_active = 0; m_n = 0; m_stream = 0; m_step = 0;
        end else begin
            m_done = 0;
            m_tv   = 0;
            if (!m_active) begin
                if (!abort && start) begin
                    m_active = 1;
                    m_n      = int'(n);
                    m_stream = stream;
                    m_step   = 0;
                    m_busy   = 1;
                end
            end else if (abort) begin
                m_active = 0;
                m_busy   = 0;
            end else begin
                m_tv   = m_stream;
                m_term = W'(fib(m_step) & MASK);
                m_idx  = NW'(m_step);
                if (m_step == m_n) begin
                    m_result = W'(fib(m_n) & MASK);
                    m_ovf    = (fib(m_n) >> W) != 0;
                    m_done   = 1;
                    m_active = 0;
                    m_busy   = 0;
                end else begin
                    m_step++;
                end
            end
        end
    end

    // ---------------- checking helpers ----------------
    longint got_terms[$];
    longint got_idx[$];
    int     exp_t[8] = '{0, 1, 1, 2, 3, 5, 8, 13};

    function automatic void check(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    // Advance to the next falling edge and compare every output to the model.
    task automatic cyc();
        @(negedge clk);
        if (reset_n) begin
            check("busy",       busy,       m_busy);
            check("done_tick",  done_tick,  m_done);
            check("result",     result,     m_result);
            check("ovf",        ovf,        m_ovf);
            check("term_valid", term_valid, m_tv);
            check("term",       term,       m_term);
            check("term_idx",   term_idx,   m_idx);
            if (term_valid) begin
                got_terms.push_back(longint'(term));
                got_idx.push_back(longint'(term_idx));
            end
        end
    endtask

    // Start a run and wait (bounded) for done_tick; returns cycles to done.
    task automatic run(input int nn, input bit st, output int cycles);
        start  = 1'b1;
        n      = NW'(nn);
        stream = st;
        cyc();
        start  = 1'b0;
        cycles = -1;
        for (int c = 1; c <= 100; c++) begin
            cyc();
            if (done_tick) begin
                cycles = c;
                break;
            end
        end
        if (cycles < 0) check("done_timeout", 0, 1);
    endtask

    // Watchdog so the bench always ends on its own.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int cyc_cnt, dones, nn, gap, abc;
    bit st, doab, got;

    initial begin
        vectors = 0; miscompares = 0;
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; stream = 1'b0; n = '0;
        repeat (3) cyc();
        check("rst_busy",   busy,       0);
        check("rst_result", result,     0);
        check("rst_done",   done_tick,  0);
        check("rst_term",   term,       0);
        reset_n = 1'b1;
        cyc();

        // n=10 without streaming
        got_terms.delete();
        run(10, 0, cyc_cnt);
        check("n10_latency", cyc_cnt, 11);
        check("n10_result",  result,  55);
        check("n10_ovf",     ovf,     0);
        check("n10_no_terms", got_terms.size(), 0);
        cyc();

        // n=0 and n=1
        run(0, 0, cyc_cnt);
        check("n0_latency", cyc_cnt, 1);
        check("n0_result",  result,  0);
        check("n0_ovf",     ovf,     0);
        run(1, 0, cyc_cnt);
        check("n1_latency", cyc_cnt, 2);
        check("n1_result",  result,  1);
        check("n1_ovf",     ovf,     0);

        // n=7 streamed
        got_terms.delete();
        got_idx.delete();
        run(7, 1, cyc_cnt);
        check("n7_result", result, 13);
        check("n7_term_count", got_terms.size(), 8);
        if (got_terms.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check("n7_term", got_terms[i], exp_t[i]);
                check("n7_idx",  got_idx[i],   i);
            end
        end
        check("n7_last_term_with_done", term_valid, 1);

        // overflow boundary
        run(24, 0, cyc_cnt);
        check("n24_result", result, 46368);
        check("n24_ovf",    ovf,    0);
        run(25, 0, cyc_cnt);
        check("n25_result", result, 9489);
        check("n25_ovf",    ovf,    1);
        run(31, 1, cyc_cnt);
        check("n31_latency", cyc_cnt, 32);
        check("n31_result",  result,  35549);
        check("n31_ovf",     ovf,     1);

        // establish a known result, then abort an n=15 run at its third cycle
        run(10, 0, cyc_cnt);
        start = 1'b1; n = NW'(15); stream = 1'b0;
        cyc();
        start = 1'b0;
        cyc(); cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done_tick) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_result_held", result, 55);

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; n = NW'(4);
        cyc();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy, 0);
        cyc();

        // start while busy is ignored
        start = 1'b1; n = NW'(5); stream = 1'b0;
        cyc();
        start = 1'b0;
        cyc();
        start = 1'b1; n = NW'(3);
        cyc();
        start = 1'b0;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (done_tick) begin got = 1; break; end
        end
        check("busy_start_done", got, 1);
        check("busy_start_result", result, 5);

        // reset in the middle of an n=20 run
        start = 1'b1; n = NW'(20); stream = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        #2 reset_n = 1'b0;
        #1;
        check("midrst_busy",   busy,       0);
        check("midrst_result", result,     0);
        check("midrst_tv",     term_valid, 0);
        check("midrst_term",   term,       0);
        check("midrst_idx",    term_idx,   0);
        check("midrst_ovf",    ovf,        0);
        cyc(); cyc();
        reset_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 25; i++) begin
            cyc();
            if (done_tick) dones++;
        end
        check("midrst_no_done", dones, 0);

        // randomized runs with optional abort and back-to-back starts
        for (int it = 0; it < 40; it++) begin
            nn   = int'($urandom_range(0, 31));
            st   = 1'($urandom_range(0, 1));
            doab = ($urandom_range(0, 3) == 0);
            abc  = int'($urandom_range(0, nn));
            start = 1'b1; n = NW'(nn); stream = st;
            cyc();
            start = 1'b0;
            got = 0;
            for (int c = 0; c < 40; c++) begin
                if (doab && c == abc) begin
                    abort = 1'b1;
                    cyc();
                    abort = 1'b0;
                    got = 1;
                    break;
                end
                cyc();
                if (done_tick) begin got = 1; break; end
            end
            check("rand_complete", got, 1);
            gap = int'($urandom_range(0, 2));
            repeat (gap) cyc();
        end

        repeat (3) cyc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
